// File: rtl/spin_echo_sequencer.sv
// spin_echo_sequencer: trigger-started CPMG sequencer (dead, pi/2, tau, N x pi, echo) driving the RF gate.
// Defining SPIN_ECHO_PHASE_EN adds the registered rf_phase output.
module spin_echo_sequencer #(
   parameter int CNT_W = 32,
   parameter int N_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trig,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_dead,
   input  logic [CNT_W-1:0] cfg_pi2,
   input  logic [CNT_W-1:0] cfg_tau,
   input  logic [N_W-1:0]   cfg_n_echo,
   output logic             rf,
`ifdef SPIN_ECHO_PHASE_EN
   output logic             rf_phase,
`endif
   output logic             busy,
   output logic             done,
   output logic [N_W-1:0]   echo_idx
);
   typedef enum logic [2:0] {IDLE, DEAD, PI2, TAU1, PI, TAU2, ECHO, FIN} state_t;
   state_t           r_st, w_ns;
   logic             r_trig, r_rf, r_busy, r_done, w_start, w_adv;
   logic [CNT_W-1:0] r_pi2, r_tau, w_pi2, w_tau;
   logic [N_W-1:0]   r_n, r_idx, w_n, w_idx;
   logic [CNT_W:0]   r_cnt, w_cnt;

   function automatic logic [CNT_W:0] dur(input state_t s, input logic [CNT_W-1:0] d, p, t);
      return (s == DEAD) ? {1'b0, d} :
             (s == PI2)  ? {1'b0, p} :
             (s == PI)   ? {p, 1'b0} :
             (s == TAU2) ? {t, 1'b0} :
             (s == TAU1 || s == ECHO) ? {1'b0, t} :
             (s == FIN)  ? (CNT_W+1)'(1) : '0;
   endfunction

   function automatic state_t succ(input state_t s, input logic [N_W-1:0] idx, n);
      return (s == DEAD) ? PI2 :
             (s == PI2)  ? ((n != '0) ? TAU1 : FIN) :
             (s == TAU1 || s == TAU2) ? PI :
             (s == PI)   ? ((idx < n) ? TAU2 : ECHO) :
             (s == ECHO) ? FIN : IDLE;
   endfunction

   assign w_start = trig && !r_trig && !abort && r_st == IDLE;
   assign w_adv   = w_start || (r_st != IDLE && r_cnt == (CNT_W+1)'(1));
   assign w_pi2   = w_start ? cfg_pi2 : r_pi2;
   assign w_tau   = w_start ? cfg_tau : r_tau;
   assign w_n     = w_start ? cfg_n_echo : r_n;

   // Zero-length states are walked through in one edge; an all-zero PI/TAU2 loop jumps straight to the last echo.
   always_comb begin
      w_ns  = r_st;
      w_idx = w_start ? '0 : r_idx;
      w_cnt = r_cnt - 1'b1;
      if (w_adv) begin
         w_ns  = w_start ? DEAD : succ(r_st, w_idx, w_n);
         w_idx = (w_ns == PI) ? w_idx + 1'b1 : w_idx;
         for (int i = 0; i < 7; i++)
            if (w_ns != IDLE && dur(w_ns, cfg_dead, w_pi2, w_tau) == '0) begin
               w_idx = (w_ns == PI && w_pi2 == '0 && w_tau == '0) ? w_n : w_idx;
               w_ns  = succ(w_ns, w_idx, w_n);
               w_idx = (w_ns == PI) ? w_idx + 1'b1 : w_idx;
            end
         w_cnt = dur(w_ns, cfg_dead, w_pi2, w_tau);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_st   <= IDLE;
         r_trig <= 1'b0;
         r_rf   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_idx  <= '0;
         r_cnt  <= '0;
         r_pi2  <= '0;
         r_tau  <= '0;
         r_n    <= '0;
      end else begin
         r_trig <= trig;
         if (abort && r_st != IDLE) begin
            r_st   <= IDLE;
            r_rf   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
         end else begin
            r_st   <= w_ns;
            r_cnt  <= w_cnt;
            r_idx  <= w_idx;
            r_rf   <= r_st == PI2 || r_st == PI;
            r_busy <= w_ns != IDLE;
            r_done <= r_st == FIN;
            if (w_start) begin
               r_pi2 <= cfg_pi2;
               r_tau <= cfg_tau;
               r_n   <= cfg_n_echo;
            end
         end
      end
   end

   assign rf       = r_rf;
   assign busy     = r_busy;
   assign done     = r_done;
   assign echo_idx = r_idx;

`ifdef SPIN_ECHO_PHASE_EN
   logic r_phase;
   always_ff @(posedge clk) begin
      if (!rst_n || (abort && r_st != IDLE))
         r_phase <= 1'b0;
      else
         r_phase <= (r_st == PI) ? 1'b1 : (r_st == PI2 || r_st == IDLE) ? 1'b0 : r_phase;
   end
   assign rf_phase = r_phase;
`endif
endmodule

// File: tb/tb_spin_echo_sequencer.sv
// tb_spin_echo_sequencer: scoreboard bench; each run's per-cycle expected outputs are built from segment lengths.
module tb_spin_echo_sequencer;
   localparam int CW = 32;
   localparam int NW = 8;

   logic          clk = 1'b0, rst_n = 1'b0, trig = 1'b0, abort = 1'b0;
   logic [CW-1:0] cfg_dead = '0, cfg_pi2 = '0, cfg_tau = '0;
   logic [NW-1:0] cfg_n_echo = '0;
   logic          rf, busy, done;
   logic [NW-1:0] echo_idx;
`ifdef SPIN_ECHO_PHASE_EN
   logic          rf_phase;
`endif

   typedef struct packed {logic rf; logic busy; logic done; logic ph; logic [NW-1:0] idx;} obs_t;
   obs_t  sb[$];
   obs_t  m_exp, m_act;
   bit    st_rf[$];
   int    st_idx[$];
   bit    st_ph[$];
   bit    cur_ph;
   int    checks = 0, failures = 0, done_cnt = 0, busy_cnt = 0, sb_cyc = 0;
   string cur_test = "none";

   always #5 clk = ~clk;

   spin_echo_sequencer #(.CNT_W(CW), .N_W(NW)) dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
      .cfg_dead(cfg_dead), .cfg_pi2(cfg_pi2), .cfg_tau(cfg_tau), .cfg_n_echo(cfg_n_echo),
      .rf(rf),
`ifdef SPIN_ECHO_PHASE_EN
      .rf_phase(rf_phase),
`endif
      .busy(busy), .done(done), .echo_idx(echo_idx)
   );

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m_exp = sb.pop_front();
         m_act.rf = rf;
         m_act.busy = busy;
         m_act.done = done;
         m_act.idx = echo_idx;
`ifdef SPIN_ECHO_PHASE_EN
         m_act.ph = rf_phase;
`else
         m_act.ph = 1'b0;
`endif
         checks++;
         if (m_act !== m_exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got rf=%b busy=%b done=%b ph=%b idx=%0d want rf=%b busy=%b done=%b ph=%b idx=%0d",
                     cur_test, sb_cyc, m_act.rf, m_act.busy, m_act.done, m_act.ph, m_act.idx,
                     m_exp.rf, m_exp.busy, m_exp.done, m_exp.ph, m_exp.idx);
         end
         done_cnt += int'(done);
         busy_cnt += int'(busy);
         sb_cyc++;
      end
   end

   task automatic add_seg(input int len, input bit r, input int idx, input int ph);
      if (len > 0 && ph >= 0) cur_ph = (ph == 1);
      for (int i = 0; i < len; i++) begin
         st_rf.push_back(r);
         st_idx.push_back(idx);
         st_ph.push_back(cur_ph);
      end
   endtask

   task automatic push_expected(input int d, p, t, n, kill_at, input bit kill_rst);
      obs_t e;
      int   tot;
      st_rf.delete();
      st_idx.delete();
      st_ph.delete();
      cur_ph = 1'b0;
      add_seg(d, 0, 0, -1);
      add_seg(p, 1, 0, 0);
      if (n > 0) begin
         add_seg(t, 0, 0, -1);
         for (int i = 1; i <= n; i++) begin
            add_seg(2 * p, 1, i, 1);
            if (i < n) add_seg(2 * t, 0, i, -1);
         end
         add_seg(t, 0, n, -1);
      end
      add_seg(1, 0, n, -1);
      tot = st_rf.size();
      for (int j = 0; j <= tot + 1; j++) begin
         e = '0;
         if (kill_at >= 0 && j > kill_at) begin
            e.idx = kill_rst ? '0 : NW'(st_idx[kill_at]);
         end else begin
            e.rf   = (j >= 1 && j <= tot) ? st_rf[j-1] : 1'b0;
            e.ph   = (j >= 1 && j <= tot) ? st_ph[j-1] : 1'b0;
            e.busy = j < tot;
            e.done = j == tot;
            e.idx  = (j < tot) ? NW'(st_idx[j]) : NW'(n);
         end
`ifndef SPIN_ECHO_PHASE_EN
         e.ph = 1'b0;
`endif
         sb.push_back(e);
         if (kill_at >= 0 && j == kill_at + 2) break;
      end
   endtask

   // Caller is at a negedge with trig low; returns at a negedge once the scoreboard has drained.
   task automatic run_seq(input string name, input int d, p, t, n, kill_at, input bit kill_rst, input int retrig_at);
      cur_test = name;
      cfg_dead = CW'(d);
      cfg_pi2 = CW'(p);
      cfg_tau = CW'(t);
      cfg_n_echo = NW'(n);
      done_cnt = 0;
      busy_cnt = 0;
      trig = 1'b1;
      @(posedge clk);
      push_expected(d, p, t, n, kill_at, kill_rst);
      sb_cyc = 0;
      @(negedge clk);
      trig = 1'b0;
      for (int j = 0; j < 1000 && sb.size() > 0; j++) begin
         if (j == retrig_at) begin
            trig = 1'b1;
            cfg_tau = cfg_tau + 7;
            cfg_pi2 = cfg_pi2 + 1;
         end
         if (j == retrig_at + 1) trig = 1'b0;
         if (j == kill_at) begin
            abort = !kill_rst;
            rst_n = !kill_rst;
         end
         if (j == kill_at + 1) begin
            abort = 1'b0;
            rst_n = 1'b1;
         end
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s timeout pending=%0d want 0", name, sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      cur_test = "reset";
      rst_n = 1'b0;
      trig = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rf, busy, done, echo_idx} !== '0) begin
         failures++;
         $display("FAIL reset_state got rf=%b busy=%b done=%b idx=%0d want all 0", rf, busy, done, echo_idx);
      end
`ifdef SPIN_ECHO_PHASE_EN
      checks++;
      if (rf_phase !== 1'b0) begin
         failures++;
         $display("FAIL reset_phase got %b want 0", rf_phase);
      end
`endif
      trig = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_echo();
      run_seq("basic_echo", 5, 3, 10, 1, -1, 0, -1);
      checks++;
      if (echo_idx !== 8'd1 || done_cnt != 1) begin
         failures++;
         $display("FAIL basic_echo_end got idx=%0d dones=%0d want idx=1 dones=1", echo_idx, done_cnt);
      end
   endtask

   task automatic test_cpmg();
      run_seq("cpmg", 3, 2, 4, 4, -1, 0, -1);
      checks++;
      if (busy_cnt != 3 + 2 + 4 + 4 * 4 + 3 * 8 + 4 + 1 || echo_idx !== 8'd4) begin
         failures++;
         $display("FAIL cpmg_busy got busy=%0d idx=%0d want busy=54 idx=4", busy_cnt, echo_idx);
      end
   endtask

   task automatic test_fid();
      run_seq("fid", 0, 5, 7, 0, -1, 0, -1);
      checks++;
      if (echo_idx !== 8'd0 || busy_cnt != 6) begin
         failures++;
         $display("FAIL fid_end got idx=%0d busy=%0d want idx=0 busy=6", echo_idx, busy_cnt);
      end
   endtask

   task automatic test_retrigger();
      run_seq("retrigger", 2, 3, 5, 2, -1, 0, 9);
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL retrigger_dones got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_abort();
      run_seq("abort_tau2", 3, 2, 4, 4, 28, 0, -1);
      checks++;
      if (echo_idx !== 8'd2 || done_cnt != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_end got idx=%0d dones=%0d busy=%b want idx=2 dones=0 busy=0", echo_idx, done_cnt, busy);
      end
      cur_test = "abort_with_trig";
      trig = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || echo_idx !== 8'd2) begin
         failures++;
         $display("FAIL abort_with_trig got busy=%b idx=%0d want busy=0 idx=2", busy, echo_idx);
      end
      repeat (2) @(negedge clk);
      run_seq("after_abort", 1, 1, 2, 1, -1, 0, -1);
   endtask

   task automatic test_reset_mid_pi();
      run_seq("reset_mid_pi", 5, 3, 10, 1, 20, 1, -1);
      run_seq("after_reset", 2, 2, 3, 2, -1, 0, -1);
   endtask

   task automatic test_zero_cfg();
      run_seq("pi2_zero", 2, 0, 3, 2, -1, 0, -1);
      run_seq("all_zero", 0, 0, 0, 3, -1, 0, -1);
   endtask

   initial begin
      test_reset();
      test_basic_echo();
      test_cpmg();
      test_fid();
      test_retrigger();
      test_abort();
      test_reset_mid_pi();
      test_zero_cfg();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
